// File: rtl/sram_port_adapter_if.sv
// Request/response channel between the core data-memory port and sram_port_adapter.
interface sram_port_adapter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/sram_port_adapter.sv
// Drives RW port 0 of an OpenRAM-style SRAM macro from a byte-addressed load/store channel.
// Define SRAM_ADAPTER_MISALIGN_TRAP_EN to reject misaligned/reserved-size accesses with rsp_err.
//
// state | meaning
// IDLE  | no response outstanding
// RESP  | response formatted live from sram_dout0
// HOLD  | consumer stalled, response served from hold registers
module sram_port_adapter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int SRAM_ADDR_WIDTH = 28,
  parameter int DATA_WIDTH      = 32,
  parameter int NUM_WMASKS      = DATA_WIDTH / 8
) (
  input  logic                       clock,
  input  logic                       reset,
  sram_port_adapter_if.slave         bus,
  output logic                       sram_csb0,
  output logic                       sram_web0,
  output logic [NUM_WMASKS-1:0]      sram_wmask0,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0]      sram_din0,
  input  logic [DATA_WIDTH-1:0]      sram_dout0
);

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {IDLE, RESP, HOLD} state_t;

  state_t                state_q, state_d;
  logic                  fire;
  logic                  bad;
  logic [1:0]            size_n;
  logic [1:0]            off_n;
  logic [NUM_WMASKS-1:0] wmask_n;
  logic [DATA_WIDTH-1:0] din_n;

  logic [1:0]            ctx_off, ctx_size;
  logic                  ctx_unsigned, ctx_we, ctx_bad;
  logic [DATA_WIDTH-1:0] hold_rdata;
  logic                  hold_err;
  logic [DATA_WIDTH-1:0] shifted, fmt_rdata;

  assign bus.req_ready = !reset && (state_q == IDLE || bus.rsp_ready);
  assign fire          = bus.req_valid && bus.req_ready;

  // Lane offset is force-aligned to the access size; with the trap enabled
  // any access that would need that alignment is flagged bad instead.
  always_comb begin
    size_n = bus.req_size;
    bad    = 1'b0;
`ifdef SRAM_ADAPTER_MISALIGN_TRAP_EN
    bad = (bus.req_size == SZ_H && bus.req_addr[0]) ||
          (bus.req_size == SZ_W && bus.req_addr[1:0] != 2'b00) ||
          (bus.req_size == 2'd3);
`else
    if (bus.req_size == 2'd3) size_n = SZ_W;
`endif
    case (size_n)
      SZ_B:    off_n = bus.req_addr[1:0];
      SZ_H:    off_n = {bus.req_addr[1], 1'b0};
      default: off_n = 2'b00;
    endcase
  end

  always_comb begin
    case (size_n)
      SZ_B: begin
        wmask_n = NUM_WMASKS'(1) << off_n;
        din_n   = {4{bus.req_wdata[7:0]}};
      end
      SZ_H: begin
        wmask_n = off_n[1] ? 4'b1100 : 4'b0011;
        din_n   = {2{bus.req_wdata[15:0]}};
      end
      default: begin
        wmask_n = 4'b1111;
        din_n   = bus.req_wdata;
      end
    endcase
  end

  always_comb begin
    sram_csb0   = !(fire && !bad);
    sram_web0   = !(fire && bus.req_we);
    sram_wmask0 = (fire && bus.req_we) ? wmask_n : '0;
    sram_addr0  = fire ? bus.req_addr[SRAM_ADDR_WIDTH+1:2] : '0;
    sram_din0   = fire ? din_n : '0;
  end

  always_comb begin
    shifted = sram_dout0 >> {ctx_off, 3'b000};
    case (ctx_size)
      SZ_B:    fmt_rdata = ctx_unsigned ? {24'b0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
      SZ_H:    fmt_rdata = ctx_unsigned ? {16'b0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
      default: fmt_rdata = shifted;
    endcase
    if (ctx_we || ctx_bad) fmt_rdata = '0;
  end

  always_comb begin
    state_d       = state_q;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = '0;
    bus.rsp_err   = 1'b0;
    case (state_q)
      IDLE: if (fire) state_d = RESP;
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = fmt_rdata;
        bus.rsp_err   = ctx_bad;
        if (!bus.rsp_ready) state_d = HOLD;
        else                state_d = fire ? RESP : IDLE;
      end
      HOLD: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = hold_rdata;
        bus.rsp_err   = hold_err;
        if (bus.rsp_ready) state_d = fire ? RESP : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      ctx_off      <= '0;
      ctx_size     <= '0;
      ctx_unsigned <= 1'b0;
      ctx_we       <= 1'b0;
      ctx_bad      <= 1'b0;
      hold_rdata   <= '0;
      hold_err     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fire) begin
        ctx_off      <= off_n;
        ctx_size     <= size_n;
        ctx_unsigned <= bus.req_unsigned;
        ctx_we       <= bus.req_we;
        ctx_bad      <= bad;
      end
      // Capture only on entry to HOLD; sram_dout0 is not guaranteed stable afterwards.
      if (state_q == RESP && !bus.rsp_ready) begin
        hold_rdata <= fmt_rdata;
        hold_err   <= ctx_bad;
      end
    end
  end

endmodule

// File: tb/tb_sram_port_adapter.sv
// Directed self-checking bench for sram_port_adapter with a small behavioural SRAM model.
module tb_sram_port_adapter;

  logic        clock = 1'b0;
  logic        reset;
  logic        sram_csb0, sram_web0;
  logic [3:0]  sram_wmask0;
  logic [27:0] sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0;
  logic [31:0] mem [0:63];

  int n_checks = 0;
  int n_errors = 0;

  logic        obs_csb, obs_web, obs_rdy, obs_rvalid, obs_err;
  logic [3:0]  obs_wmask;
  logic [27:0] obs_addr;
  logic [31:0] obs_din, obs_rdata;

  logic [31:0] b2b_val [0:3];

  sram_port_adapter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  sram_port_adapter dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus.slave),
    .sram_csb0   (sram_csb0),
    .sram_web0   (sram_web0),
    .sram_wmask0 (sram_wmask0),
    .sram_addr0  (sram_addr0),
    .sram_din0   (sram_din0),
    .sram_dout0  (sram_dout0)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        for (int i = 0; i < 4; i++)
          if (sram_wmask0[i]) mem[sram_addr0[5:0]][i*8 +: 8] <= sram_din0[i*8 +: 8];
      end else begin
        sram_dout0 <= mem[sram_addr0[5:0]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One request with rsp_ready high; records macro drive in the fire cycle and the response one cycle later.
  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge clock); #1;
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.rsp_ready    = 1'b1;
    @(negedge clock);
    obs_rdy   = bus.req_ready;
    obs_csb   = sram_csb0;
    obs_web   = sram_web0;
    obs_wmask = sram_wmask0;
    obs_addr  = sram_addr0;
    obs_din   = sram_din0;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    @(negedge clock);
    obs_rvalid = bus.rsp_valid;
    obs_rdata  = bus.rsp_rdata;
    obs_err    = bus.rsp_err;
    chk("req_ready_at_fire", 32'(obs_rdy), 32'd1);
    chk("rsp_valid_after_fire", 32'(obs_rvalid), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    sram_dout0 = '0;
    b2b_val[0] = 32'hDEADBEEF;
    b2b_val[1] = 32'h01234567;
    b2b_val[2] = 32'hCAFEF00D;
    b2b_val[3] = 32'h5A5A0F0F;

    reset            = 1'b1;
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'd2;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;
    bus.rsp_ready    = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("reset_req_ready", 32'(bus.req_ready), 32'd0);
      chk("reset_csb0", 32'(sram_csb0), 32'd1);
      chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    end
    @(posedge clock); #1;
    reset         = 1'b0;
    bus.req_valid = 1'b0;

    // sb 0xA5 -> 0x6
    access(1'b1, 2'd0, 1'b0, 32'h0000_0006, 32'h0000_00A5);
    chk("sb_csb0", 32'(obs_csb), 32'd0);
    chk("sb_web0", 32'(obs_web), 32'd0);
    chk("sb_wmask0", 32'(obs_wmask), 32'b0100);
    chk("sb_din0", obs_din, 32'hA5A5_A5A5);
    chk("sb_addr0", 32'(obs_addr), 32'd1);
    chk("sb_rdata", obs_rdata, 32'h0);
    chk("sb_err", 32'(obs_err), 32'd0);
    access(1'b0, 2'd2, 1'b0, 32'h0000_0004, 32'h0);
    chk("lw4_wmask0", 32'(obs_wmask), 32'd0);
    chk("lw4_web0", 32'(obs_web), 32'd1);
    chk("lw4_rdata", obs_rdata, 32'h00A5_0000);

    // sh to upper half lane
    access(1'b1, 2'd1, 1'b0, 32'h0000_000E, 32'hFFFF_1234);
    chk("sh_wmask0", 32'(obs_wmask), 32'b1100);
    chk("sh_din0", obs_din, 32'h1234_1234);
    chk("sh_addr0", 32'(obs_addr), 32'd3);
    access(1'b0, 2'd2, 1'b0, 32'h0000_000C, 32'h0);
    chk("lw_c_rdata", obs_rdata, 32'h1234_0000);

    access(1'b1, 2'd2, 1'b0, 32'h0000_0008, 32'h80FF_7F01);
    chk("sw8_wmask0", 32'(obs_wmask), 32'b1111);
    chk("sw8_din0", obs_din, 32'h80FF_7F01);
    access(1'b0, 2'd0, 1'b1, 32'h0000_0009, 32'h0);
    chk("lbu_9", obs_rdata, 32'h0000_007F);
    access(1'b0, 2'd0, 1'b0, 32'h0000_000A, 32'h0);
    chk("lb_a", obs_rdata, 32'hFFFF_FFFF);
    access(1'b0, 2'd1, 1'b0, 32'h0000_000A, 32'h0);
    chk("lh_a", obs_rdata, 32'hFFFF_80FF);
    access(1'b0, 2'd1, 1'b1, 32'h0000_0008, 32'h0);
    chk("lhu_8", obs_rdata, 32'h0000_7F01);
    access(1'b0, 2'd0, 1'b0, 32'h0000_0008, 32'h0);
    chk("lb_8", obs_rdata, 32'h0000_0001);

    for (int k = 0; k < 4; k++) access(1'b1, 2'd2, 1'b0, 32'h10 + 32'(4*k), b2b_val[k]);

    // back-to-back loads, rsp_ready held high
    for (int k = 0; k < 4; k++) begin
      @(posedge clock); #1;
      bus.req_valid    = 1'b1;
      bus.req_we       = 1'b0;
      bus.req_size     = 2'd2;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'h10 + 32'(4*k);
      bus.rsp_ready    = 1'b1;
      @(negedge clock);
      chk("b2b_req_ready", 32'(bus.req_ready), 32'd1);
      chk("b2b_csb0", 32'(sram_csb0), 32'd0);
      if (k > 0) begin
        chk("b2b_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("b2b_rdata", bus.rsp_rdata, b2b_val[k-1]);
      end
    end
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    @(negedge clock);
    chk("b2b_last_valid", 32'(bus.rsp_valid), 32'd1);
    chk("b2b_last_rdata", bus.rsp_rdata, b2b_val[3]);
    @(posedge clock); #1;
    @(negedge clock);
    chk("b2b_idle", 32'(bus.rsp_valid), 32'd0);

    // consumer stall for 5 cycles with a competing request pending
    @(posedge clock); #1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h10;
    bus.rsp_ready = 1'b0;
    @(negedge clock);
    chk("stall_fire_csb0", 32'(sram_csb0), 32'd0);
    @(posedge clock); #1;
    bus.req_addr = 32'h14;
    repeat (5) begin
      @(negedge clock);
      chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("stall_rdata", bus.rsp_rdata, b2b_val[0]);
      chk("stall_req_ready", 32'(bus.req_ready), 32'd0);
      chk("stall_csb0", 32'(sram_csb0), 32'd1);
      @(posedge clock); #1;
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clock);
    chk("release_valid", 32'(bus.rsp_valid), 32'd1);
    chk("release_rdata", bus.rsp_rdata, b2b_val[0]);
    @(posedge clock); #1;
    @(negedge clock);
    chk("release_once", 32'(bus.rsp_valid), 32'd0);

    // misaligned / reserved-size accesses against word 0
    access(1'b1, 2'd2, 1'b0, 32'h0000_0000, 32'h1122_3344);
    access(1'b0, 2'd2, 1'b0, 32'h0000_0002, 32'h0);
`ifdef SRAM_ADAPTER_MISALIGN_TRAP_EN
    chk("mis_lw_csb0", 32'(obs_csb), 32'd1);
    chk("mis_lw_err", 32'(obs_err), 32'd1);
    chk("mis_lw_rdata", obs_rdata, 32'h0);
    access(1'b0, 2'd1, 1'b0, 32'h0000_0003, 32'h0);
    chk("mis_lh_err", 32'(obs_err), 32'd1);
    access(1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0);
    chk("sz3_err", 32'(obs_err), 32'd1);
    chk("sz3_rdata", obs_rdata, 32'h0);
    access(1'b1, 2'd2, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF);
    chk("mis_sw_csb0", 32'(obs_csb), 32'd1);
    access(1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'h0);
    chk("mis_sw_no_write", obs_rdata, 32'h1122_3344);
`else
    chk("mis_lw_csb0", 32'(obs_csb), 32'd0);
    chk("mis_lw_addr0", 32'(obs_addr), 32'd0);
    chk("mis_lw_err", 32'(obs_err), 32'd0);
    chk("mis_lw_rdata", obs_rdata, 32'h1122_3344);
    access(1'b0, 2'd1, 1'b0, 32'h0000_0003, 32'h0);
    chk("mis_lh_rdata", obs_rdata, 32'h0000_1122);
    access(1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'h0);
    chk("sz3_rdata", obs_rdata, 32'h1122_3344);
    chk("sz3_err", 32'(obs_err), 32'd0);
    access(1'b1, 2'd2, 1'b0, 32'h0000_0001, 32'hAABB_CCDD);
    chk("mis_sw_wmask0", 32'(obs_wmask), 32'b1111);
    chk("mis_sw_din0", obs_din, 32'hAABB_CCDD);
`endif

    // reset mid-transaction drops the pending response
    @(posedge clock); #1;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'd2;
    bus.req_addr  = 32'h10;
    bus.rsp_ready = 1'b0;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    reset         = 1'b1;
    @(negedge clock);
    chk("rst_mid_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_mid_csb0", 32'(sram_csb0), 32'd1);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_mid_rdata", bus.rsp_rdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_port_adapter.md
Name: sram_port_adapter

Overview:
- Sits directly upstream of the dual-port OpenRAM-style SRAM macro, driving its RW port 0 on behalf of the core's data-memory interface.
- Converts a byte-addressed valid/ready request channel (load/store, byte/half/word) into macro signals:
  - active-low chip select and write enable;
  - per-byte write mask;
  - word address;
  - lane-replicated write data.
- Aligns and sign/zero-extends returned load data.
- Returns one response per request on a valid/ready channel.

Parameters:
- ADDR_WIDTH, 32, width of the byte address on the request channel.
- SRAM_ADDR_WIDTH, 28, word-address width of the macro port.
- DATA_WIDTH, 32, data width. Only 32 is supported.
- NUM_WMASKS, 4, byte-enable count, equal to DATA_WIDTH/8.

Ports:
- clock  input  1  single clock, same clock that feeds the macro clk0.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  adapter accepts the request this cycle.
- req_addr  input  ADDR_WIDTH  byte address.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- req_wdata  input  DATA_WIDTH  store data, right-aligned.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer takes the response.
- rsp_rdata  output  DATA_WIDTH  extended load data; 0 for stores and errors.
- rsp_err  output  1  access rejected.
- sram_csb0  output  1  macro chip select, active low.
- sram_web0  output  1  macro write enable, active low.
- sram_wmask0  output  NUM_WMASKS  macro byte write mask.
- sram_addr0  output  SRAM_ADDR_WIDTH  macro word address.
- sram_din0  output  DATA_WIDTH  macro write data.
- sram_dout0  input  DATA_WIDTH  macro read data, valid in the cycle after the access.

Behaviour:
- Reset values and reset behaviour:
  - State IDLE; rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
  - Hold and context registers are cleared.
  - While reset is high, req_ready = 0 and sram_csb0 = 1.
  - A reset asserted mid-transaction drops any pending response. No partial write is issued after reset.
- Handshake:
  - fire = req_valid & req_ready.
  - req_ready = !reset & (state == IDLE | rsp_ready).
  - Throughput is one access per cycle when rsp_ready is held high.
- Macro drive (combinational, in the fire cycle only; the macro registers its inputs on the following posedge):
  - sram_csb0 = !(fire & !bad).
  - sram_web0 = !req_we.
  - sram_addr0 = req_addr[SRAM_ADDR_WIDTH+1:2]. Upper address bits are ignored.
  - In all non-fire cycles: csb0 = 1, web0 = 1, wmask0 = 0, addr0 = 0, din0 = 0.
- Store lanes (off = req_addr[1:0]):
  - Byte: wmask = 1 << off; din = wdata[7:0] replicated x4.
  - Half: wmask = off[1] ? 1100 : 0011; din = wdata[15:0] replicated x2.
  - Word: wmask = 1111; din = wdata.
  - Loads drive wmask = 0.
- Context capture: on fire, latch off, size, unsigned, we and bad.
- States:
  - IDLE:
    - fire -> RESP.
  - RESP (rsp_valid = 1):
    - rsp_rdata is formatted combinationally from sram_dout0. For a load: shift right by off*8, mask to the access size, then sign- or zero-extend. Stores return 0.
    - rsp_ready & fire -> RESP.
    - rsp_ready & !fire -> IDLE.
    - !rsp_ready -> latch the formatted data and error into hold registers, go to HOLD.
  - HOLD (rsp_valid = 1):
    - Outputs come from the hold registers.
    - Exit transitions are identical to RESP.
- Latency: response is valid exactly 1 cycle after fire, and stays stable until taken.
- bad is derived per the optional feature. A bad access does not touch the macro (csb0 stays 1) and returns rsp_err = 1 with rdata = 0.
- Simultaneous response take and new request: allowed. The new access is issued in the same cycle the old response retires. The old data is not corrupted, because the macro updates dout0 only after the following posedge.

Optional Feature:
- Macro: SRAM_ADAPTER_MISALIGN_TRAP_EN.
- Defined: bad = (half & off[0]) | (word & off != 0) | (size == 3).
- Not defined: bad = 0.
  - Size 3 is treated as word.
  - Misaligned accesses use forced alignment: half uses off & 2, word uses off = 0.
  - rsp_err is tied to 0.

Test Plan:
- Reset held 3 cycles with req_valid = 1 -> req_ready = 0, sram_csb0 = 1, rsp_valid = 0 throughout.
- Store byte 0xA5 to addr 0x0000_0006 -> wmask0 = 0100, din0 = 0xA5A5A5A5, addr0 = 1. Then load word addr 0x4 returns 0x00A50000, given memory initialised to zero.
- Word at 0x8 = 0x80FF7F01: lbu 0x9 -> 0x0000007F; lb 0xA -> 0xFFFFFFFF; lh 0xA -> 0xFFFF80FF; lhu 0x8 -> 0x00007F01.
- Four back-to-back loads with rsp_ready = 1 -> one response per cycle, in order, each 1 cycle after its fire.
- rsp_ready = 0 for 5 cycles during RESP -> rsp_rdata and rsp_valid stable, req_ready = 0, no macro access (csb0 = 1). Release -> data delivered once.
- With the macro defined: lw at 0x2 -> csb0 = 1, rsp_err = 1, rdata = 0. Without it: the same lw reads word 0 and rsp_err = 0.
